// File: rtl/inst_rom_arbiter_if.sv
// Bus bundle between the two ROM masters, the arbiter and the ROM.
// slave: arbiter view; master: requester/ROM-model view (bench side).
interface inst_rom_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m0_err;

    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          m1_err;

    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_inst;

    modport slave (
        input  m0_req, m0_addr,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_addr,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output rom_ce, rom_addr,
        input  rom_inst
    );

    modport master (
        output m0_req, m0_addr,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_addr,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  rom_ce, rom_addr,
        output rom_inst
    );
endinterface

// File: rtl/inst_rom_arbiter.sv
// Two-master arbiter for the single-port instruction ROM (m0 = fetch,
// m1 = debug/loader). One grant per cycle, registered 1-cycle response.
// Ports: clk, rst (async, active-high), bus (inst_rom_arbiter_if.slave):
//   mX_req/mX_addr in, mX_gnt (comb), mX_rvalid/mX_rdata/mX_err (reg),
//   rom_ce/rom_addr out (comb), rom_inst in.
// Optional macro ARB_ROUND_ROBIN_EN: alternate on contention instead of
// fixed m0 priority with the MAX_WAIT starvation guard.
module inst_rom_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_rom_arbiter_if.slave     bus
);

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } grant_e;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0]    wait_cnt;
    grant_e        last_grant;

    logic          gnt0;
    logic          gnt1;
    logic [AW-1:0] sel_addr;
    logic          misaligned;

    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          err0_q;
    logic          err1_q;

    // Grant decision; everything is held low while rst is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (bus.m0_req && bus.m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_grant == GNT_M0) gnt1 = 1'b1;
                else                      gnt0 = 1'b1;
`else
                if (wait_cnt == WAIT_MAX) gnt1 = 1'b1;
                else                      gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = bus.m0_req;
                gnt1 = bus.m1_req;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        if (gnt1)      sel_addr = bus.m1_addr;
        else if (gnt0) sel_addr = bus.m0_addr;
    end

    // A misaligned access keeps its slot but never touches the ROM.
    assign misaligned = (gnt0 || gnt1) && (sel_addr[1:0] != 2'b00);

    assign bus.m0_gnt   = gnt0;
    assign bus.m1_gnt   = gnt1;
    assign bus.rom_ce   = (gnt0 || gnt1) && !misaligned;
    assign bus.rom_addr = sel_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            last_grant <= GNT_M0;
        end else begin
            if (bus.m1_req && !gnt1) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (gnt0)      last_grant <= GNT_M0;
            else if (gnt1) last_grant <= GNT_M1;
        end
    end

    // Response registers: rdata holds between pulses, err does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1;
            err0_q    <= gnt0 && misaligned;
            err1_q    <= gnt1 && misaligned;
            if (gnt0) rdata0_q <= misaligned ? '0 : bus.rom_inst;
            if (gnt1) rdata1_q <= misaligned ? '0 : bus.rom_inst;
        end
    end

    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.m0_err    = err0_q;
    assign bus.m1_err    = err1_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed self-checking bench for inst_rom_arbiter.
// Drives 1 time unit after posedge, samples on negedge.
module tb_inst_rom_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    inst_rom_arbiter_if #(.AW(32), .DW(32)) bus ();

    inst_rom_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ROM model: word i = A5A5_0000 + i, zero when not enabled.
    function automatic logic [31:0] word(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    assign bus.rom_inst = bus.rom_ce ? (32'hA5A5_0000 + {2'b00, bus.rom_addr[31:2]}) : 32'h0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r0;
        logic [31:0] a0;
        logic        r1;
        logic [31:0] a1;
        logic        g0;
        logic        g1;
        logic        ce;
        logic [31:0] ra;
        logic        v0;
        logic [31:0] d0;
        logic        e0;
        logic        v1;
        logic [31:0] d1;
        logic        e1;
    } vec_t;

    vec_t vt [13];

    task automatic drive(input logic r0, input logic [31:0] a0,
                         input logic r1, input logic [31:0] a1);
        bus.m0_req  = r0;
        bus.m0_addr = a0;
        bus.m1_req  = r1;
        bus.m1_addr = a1;
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk({tag, ".m0_gnt"},    32'(bus.m0_gnt),    32'(v.g0));
        chk({tag, ".m1_gnt"},    32'(bus.m1_gnt),    32'(v.g1));
        chk({tag, ".rom_ce"},    32'(bus.rom_ce),    32'(v.ce));
        chk({tag, ".rom_addr"},  bus.rom_addr,       v.ra);
        chk({tag, ".m0_rvalid"}, 32'(bus.m0_rvalid), 32'(v.v0));
        chk({tag, ".m0_rdata"},  bus.m0_rdata,       v.d0);
        chk({tag, ".m0_err"},    32'(bus.m0_err),    32'(v.e0));
        chk({tag, ".m1_rvalid"}, 32'(bus.m1_rvalid), 32'(v.v1));
        chk({tag, ".m1_rdata"},  bus.m1_rdata,       v.d1);
        chk({tag, ".m1_err"},    32'(bus.m1_err),    32'(v.e1));
    endtask

    logic exp_g1 [8];

    initial begin
        //         r0 a0     r1 a1      g0 g1 ce ra      v0 d0        e0 v1 d1       e1
        vt[0]  = '{0, 0,     0, 0,      0, 0, 0, 0,      0, 0,        0, 0, 0,       0};
        vt[1]  = '{1, 32'h8, 0, 0,      1, 0, 1, 32'h8,  0, 0,        0, 0, 0,       0};
        vt[2]  = '{1, 32'h0, 0, 0,      1, 0, 1, 32'h0,  1, word(2),  0, 0, 0,       0};
        vt[3]  = '{1, 32'h4, 0, 0,      1, 0, 1, 32'h4,  1, word(0),  0, 0, 0,       0};
        vt[4]  = '{1, 32'h8, 0, 0,      1, 0, 1, 32'h8,  1, word(1),  0, 0, 0,       0};
        vt[5]  = '{1, 32'hC, 0, 0,      1, 0, 1, 32'hC,  1, word(2),  0, 0, 0,       0};
        vt[6]  = '{0, 0,     0, 0,      0, 0, 0, 0,      1, word(3),  0, 0, 0,       0};
        vt[7]  = '{0, 0,     0, 0,      0, 0, 0, 0,      0, word(3),  0, 0, 0,       0};
        vt[8]  = '{0, 0,     1, 32'h6,  0, 1, 0, 32'h6,  0, word(3),  0, 0, 0,       0};
        vt[9]  = '{0, 0,     1, 32'h10, 0, 1, 1, 32'h10, 0, word(3),  0, 1, 0,       1};
        vt[10] = '{1, 32'h2, 0, 0,      1, 0, 0, 32'h2,  0, word(3),  0, 1, word(4), 0};
        vt[11] = '{0, 0,     0, 0,      0, 0, 0, 0,      1, 0,        1, 0, word(4), 0};
        vt[12] = '{0, 0,     0, 0,      0, 0, 0, 0,      0, 0,        0, 0, word(4), 0};

        // Reset state with both masters requesting.
        drive(1, 32'h4, 1, 32'h8);
        #2;
        chk("rst.m0_gnt", 32'(bus.m0_gnt), 0);
        chk("rst.m1_gnt", 32'(bus.m1_gnt), 0);
        chk("rst.rom_ce", 32'(bus.rom_ce), 0);
        chk("rst.rom_addr", bus.rom_addr, 0);
        chk("rst.m0_rvalid", 32'(bus.m0_rvalid), 0);
        chk("rst.m1_rdata", bus.m1_rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            drive(vt[i].r0, vt[i].a0, vt[i].r1, vt[i].a1);
            @(negedge clk);
            chk_vec($sformatf("vec%0d", i), vt[i]);
        end

        // Reset right after an m0 grant: response is discarded.
        @(posedge clk);
        #1;
        drive(1, 32'h4, 0, 0);
        @(negedge clk);
        chk("rmid.m0_gnt", 32'(bus.m0_gnt), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rmid.m0_rvalid", 32'(bus.m0_rvalid), 0);
        chk("rmid.m0_rdata", bus.m0_rdata, 0);
        chk("rmid.m0_gnt", 32'(bus.m0_gnt), 0);
        chk("rmid.rom_ce", 32'(bus.rom_ce), 0);
        chk("rmid.m1_rdata", bus.m1_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rpost%0d.m0_rvalid", i), 32'(bus.m0_rvalid), 0);
            chk($sformatf("rpost%0d.m1_rvalid", i), 32'(bus.m1_rvalid), 0);
        end

        // Contention from a fresh reset (wait_cnt=0, last_grant=m0).
        for (int k = 0; k < 8; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_g1[k] = (k % 2 == 0);
`else
            exp_g1[k] = (k == 4);
`endif
        end
        @(posedge clk);
        #1;
        drive(1, 32'h0, 1, 32'h14);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("cont%0d.m1_gnt", k), 32'(bus.m1_gnt), 32'(exp_g1[k]));
            chk($sformatf("cont%0d.m0_gnt", k), 32'(bus.m0_gnt), 32'(!exp_g1[k]));
            chk($sformatf("cont%0d.rom_addr", k), bus.rom_addr,
                exp_g1[k] ? 32'h14 : 32'h0);
            if (k > 0) begin
                chk($sformatf("cont%0d.m1_rvalid", k), 32'(bus.m1_rvalid),
                    32'(exp_g1[k-1]));
                chk($sformatf("cont%0d.m0_rvalid", k), 32'(bus.m0_rvalid),
                    32'(!exp_g1[k-1]));
            end
            if (k > 0 && exp_g1[k-1])
                chk($sformatf("cont%0d.m1_rdata", k), bus.m1_rdata, word(5));
            if (k > 0 && !exp_g1[k-1])
                chk($sformatf("cont%0d.m0_rdata", k), bus.m0_rdata, word(0));
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
